// File: rtl/prog_instr_mem.sv
// prog_instr_mem: DATA_W x DEPTH instruction store with a single-cycle fetch
// port and a valid/ready program loader. Fetch is stalled while a load
// session is in progress.
module prog_instr_mem #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    // fetch port
    input  logic              F_REQ,
    input  logic [ADDR_W-1:0] F_ADDR,
    output logic              F_GNT,
    output logic [DATA_W-1:0] Q,
    output logic              Q_VALID,
    output logic              Q_ERR,
    // loader port
    input  logic              LD_START,
    input  logic [ADDR_W-1:0] LD_BASE,
    input  logic [ADDR_W:0]   LD_COUNT,
    input  logic              LD_VALID,
    input  logic [DATA_W-1:0] LD_DATA,
    output logic              LD_READY,
    output logic              LD_DONE,
    output logic              BUSY
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    // DEPTH <= 2^ADDR_W, so it always fits in the count width
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOAD = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;
    logic [CNT_W-1:0]  rem;
    logic [CNT_W-1:0]  rem_nxt;
    logic              done_nxt;
    logic              wr_en;

    logic [CNT_W-1:0]  start_cnt;
    logic [ADDR_W-1:0] start_ptr;
    logic              fetch_hit;

    logic [DATA_W-1:0] mem [DEPTH];

    // Session parameters: clamp the count to the array size, fold an
    // out-of-range base back to address 0.
    assign start_cnt = (LD_COUNT > DEPTH_CNT) ? DEPTH_CNT : LD_COUNT;
    assign start_ptr = ({1'b0, LD_BASE} >= DEPTH_CNT) ? '0 : LD_BASE;

    // Fetch address lies inside the populated part of the address space
    assign fetch_hit = ({1'b0, F_ADDR} < DEPTH_CNT);

    // State-derived handshake and status
    assign LD_READY = (state == S_LOAD);
    assign BUSY     = (state == S_LOAD);
    assign F_GNT    = F_REQ && (state == S_IDLE);

    // State, pointer, remaining count and done pulse registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            ptr     <= '0;
            rem     <= '0;
            LD_DONE <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            rem     <= rem_nxt;
            LD_DONE <= done_nxt;
        end
    end

    // Next-state logic: session start in IDLE, one word per valid beat in LOAD
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        case (state)
            S_IDLE: begin
                if (LD_START) begin
                    ptr_nxt = start_ptr;
                    rem_nxt = start_cnt;
                    if (start_cnt == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (LD_VALID) begin
                    wr_en   = 1'b1;
                    ptr_nxt = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
                    rem_nxt = rem - CNT_W'(1);
                    if (rem == CNT_W'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Storage array write; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[ptr] <= LD_DATA;
        end
    end

    // Registered fetch data; an out-of-range grant keeps Q and flags the error
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            Q_ERR   <= 1'b0;
        end else begin
            Q_VALID <= F_GNT;
            Q_ERR   <= F_GNT && !fetch_hit;
            if (F_GNT && fetch_hit) begin
                Q <= mem[F_ADDR];
            end
        end
    end

endmodule

// File: doc/prog_instr_mem.md
# prog_instr_mem

Parametrised instruction memory with a single-cycle fetch port and a streaming program loader. It sits between the instruction fetch stage and the boot/debug loader. A load session writes a run of consecutive words from a valid/ready stream into the array, and fetch is stalled for the duration of the session. It replaces the fixed 13x16 instruction store with a generic DATA_W x DEPTH store.

## Interface
- DATA_W, 13, instruction word width
- DEPTH, 16, number of words; any value >= 2, not limited to powers of two
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH
- CLK  in  1  rising-edge clock
- RST_N  in  1  reset; asynchronous, active-low
- F_REQ  in  1  fetch request
- F_ADDR  in  ADDR_W  fetch address
- F_GNT  out  1  fetch accepted this cycle; combinational, equals F_REQ && state==IDLE
- Q  out  DATA_W  registered fetch data
- Q_VALID  out  1  Q updated by the previous cycle's grant
- Q_ERR  out  1  the previous grant addressed a location >= DEPTH
- LD_START  in  1  start a load session; sampled only in IDLE
- LD_BASE  in  ADDR_W  first write address; sampled with LD_START
- LD_COUNT  in  ADDR_W+1  number of words to write; sampled with LD_START
- LD_VALID  in  1  stream word present
- LD_DATA  in  DATA_W  stream word
- LD_READY  out  1  high exactly while state==LOAD
- LD_DONE  out  1  one-cycle pulse when a session ends
- BUSY  out  1  state==LOAD

## Operation
- State machine with two states, IDLE and LOAD. Reset enters IDLE.
- **Reset values:** Q=0, Q_VALID=0, Q_ERR=0, LD_DONE=0, write pointer=0, remaining count=0. The array is not cleared. Contents are undefined until written.
- **Fetch in IDLE**
  - With F_REQ=1 and F_ADDR<DEPTH, the edge latches Q=mem[F_ADDR], Q_VALID=1 and Q_ERR=0.
  - With F_ADDR>=DEPTH, the edge leaves Q unchanged and sets Q_VALID=1 and Q_ERR=1.
  - With no grant, Q holds its value and Q_VALID=0 and Q_ERR=0.
- **Starting a session:** LD_START=1 in IDLE latches ptr=LD_BASE and rem=min(LD_COUNT, DEPTH).
  - If LD_BASE>=DEPTH, ptr is set to 0 instead.
  - If rem>0, the state moves to LOAD.
  - If rem==0, the state stays IDLE and LD_DONE pulses on the next cycle.
- **Writing in LOAD:** each cycle with LD_VALID && LD_READY writes mem[ptr]=LD_DATA.
  - ptr advances and wraps from DEPTH-1 to 0.
  - rem decrements.
  - On the write that makes rem reach 0, the state returns to IDLE and LD_DONE=1 for exactly the following cycle.
- LD_VALID low in LOAD inserts a bubble: no write and no state change.
- LD_START during LOAD is ignored.
- F_REQ during LOAD gets F_GNT=0. The requester holds its request; no request is queued internally.
- LD_START and F_REQ in the same IDLE cycle: the fetch is granted and completes normally, and LOAD begins next cycle.
- RST_N asserted mid-session abandons the session. Words already written remain, and LD_DONE does not pulse.

## Timing
- Fetch latency is 1 cycle: grant at edge N gives Q and Q_VALID valid in cycle N+1. Throughput is 1 fetch per cycle in IDLE.
- Load throughput is 1 word per cycle while LD_VALID stays high. A session of C words with no bubbles occupies C cycles in LOAD.
- LD_DONE is high in the cycle after the final write. That cycle is also the first IDLE cycle: F_GNT can be 1, and the fetch returns the newly written data.
- Read-after-write across the session boundary always returns the new word. There is no stale bypass.
- Reset is asynchronous: outputs reach their reset values immediately on RST_N low. Deassertion is synchronised externally.

## Test plan
- **Reset:** assert RST_N=0 mid-cycle -> Q=0, Q_VALID=0, LD_READY=0, BUSY=0 immediately, without waiting for a clock edge.
- **Basic load then fetch:** LD_START with BASE=3, COUNT=4; stream 0x0A1,0x0A2,0x0A3,0x0A4 with no bubbles -> LD_DONE pulses one cycle after the 4th write. Fetches of 3,4,5,6 give those words at a 1-cycle latency, with Q_VALID high on consecutive cycles.
- **Wrap and bubbles:** BASE=14, COUNT=5, DEPTH=16, LD_VALID toggling 1,0,1,1,0,1,1 -> addresses 14,15,0,1,2 are written. BUSY stays high 7 cycles, and LD_READY is high throughout.
- **Fetch stall:** hold F_REQ during LOAD -> F_GNT=0 until the LD_DONE cycle, then F_GNT=1. The next-cycle Q equals the just-loaded word.
- **Edge counts:** COUNT=0 -> no LOAD, LD_DONE pulses next cycle. COUNT=31 with DEPTH=16 -> exactly 16 writes.
- **Non-power-of-two:** DEPTH=12, ADDR_W=4. Fetch address 13 -> Q_VALID=1, Q_ERR=1, Q unchanged. A load with BASE=11, COUNT=2 writes addresses 11 and 0.
- **Reset mid-load:** assert RST_N low after 2 of 5 words -> state is IDLE and LD_DONE never pulses. The 2 written words read back correctly.
